// File: rtl/video_mode_sequencer.sv
// Sequencer for the HDMI timing core: gates en_o and holds the active timing set,
// applying staged updates only at frame boundaries. Optional validity check: VIDEO_SEQ_CHECK_EN.
module video_mode_sequencer #(
    parameter int unsigned TW           = 12,
    parameter int unsigned H_ACTIVE_DEF = 1920,
    parameter int unsigned H_FRONT_DEF  = 88,
    parameter int unsigned H_SYNC_DEF   = 44,
    parameter int unsigned H_TOTAL_DEF  = 2200,
    parameter int unsigned V_ACTIVE_DEF = 1080,
    parameter int unsigned V_FRONT_DEF  = 4,
    parameter int unsigned V_SYNC_DEF   = 5,
    parameter int unsigned V_TOTAL_DEF  = 1125
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          cfg_wr_i,
    input  logic [2:0]    cfg_addr_i,
    input  logic [TW-1:0] cfg_data_i,
    input  logic          commit_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          frame_start_i,
    output logic          en_o,
    output logic [TW-1:0] h_active_o,
    output logic [TW-1:0] h_front_o,
    output logic [TW-1:0] h_sync_o,
    output logic [TW-1:0] h_total_o,
    output logic [TW-1:0] v_active_o,
    output logic [TW-1:0] v_front_o,
    output logic [TW-1:0] v_sync_o,
    output logic [TW-1:0] v_total_o,
    output logic          cfg_busy_o,
    output logic          cfg_done_o,
    output logic          cfg_err_o
);

    localparam int unsigned NREG = 8;
    localparam logic [TW-1:0] DEF [NREG] = '{
        TW'(H_ACTIVE_DEF), TW'(H_FRONT_DEF), TW'(H_SYNC_DEF), TW'(H_TOTAL_DEF),
        TW'(V_ACTIVE_DEF), TW'(V_FRONT_DEF), TW'(V_SYNC_DEF), TW'(V_TOTAL_DEF)
    };

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUN      = 2'd1,
        PENDING  = 2'd2,
        STOPPING = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          stop_pend_q, stop_pend_d;
    logic          load_c;
    logic          en_d, busy_d;
    logic          valid_c;
    logic [TW-1:0] stg [NREG];
    logic [TW-1:0] act [NREG];

    // Staging registers: frozen while a commit or stop is outstanding
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stg <= DEF;
        end else if (cfg_wr_i && !cfg_busy_o) begin
            stg[cfg_addr_i] <= cfg_data_i;
        end
    end

`ifdef VIDEO_SEQ_CHECK_EN
    localparam int unsigned SW = TW + 2;
    logic [SW-1:0] h_sum_c, v_sum_c;
    logic          commit_try_c;

    assign h_sum_c      = SW'(stg[0]) + SW'(stg[1]) + SW'(stg[2]);
    assign v_sum_c      = SW'(stg[4]) + SW'(stg[5]) + SW'(stg[6]);
    assign valid_c      = (h_sum_c < SW'(stg[3])) && (v_sum_c < SW'(stg[7]));
    assign commit_try_c = commit_i && !cfg_busy_o;

    // Sticky error: reflects the outcome of the most recent considered commit
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_err_o <= 1'b0;
        end else if (commit_try_c) begin
            cfg_err_o <= !valid_c;
        end
    end
`else
    assign valid_c   = 1'b1;
    assign cfg_err_o = 1'b0;
`endif

    // State, control outputs and active timing set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= STOPPED;
            stop_pend_q <= 1'b0;
            en_o        <= 1'b0;
            cfg_busy_o  <= 1'b0;
            cfg_done_o  <= 1'b0;
            act         <= DEF;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            en_o        <= en_d;
            cfg_busy_o  <= busy_d;
            cfg_done_o  <= load_c;
            if (load_c) begin
                act <= stg;
            end
        end
    end

    // Next-state logic; stop_i always beats start_i when both arrive together
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        load_c      = 1'b0;

        case (state_q)
            STOPPED: begin
                if (commit_i && valid_c) begin
                    load_c = 1'b1;
                end
                if (start_i && !stop_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (commit_i && valid_c) begin
                    state_d     = PENDING;
                    stop_pend_d = stop_i;
                end else if (stop_i) begin
                    state_d = STOPPING;
                end
            end
            PENDING: begin
                if (stop_i) begin
                    stop_pend_d = 1'b1;
                end else if (start_i) begin
                    stop_pend_d = 1'b0;
                end
                if (frame_start_i) begin
                    load_c      = 1'b1;
                    stop_pend_d = 1'b0;
                    state_d     = (stop_i || (stop_pend_q && !start_i)) ? STOPPING : RUN;
                end
            end
            STOPPING: begin
                if (stop_i) begin
                    if (frame_start_i) begin
                        state_d = STOPPED;
                    end
                end else if (start_i) begin
                    state_d = RUN;
                end else if (frame_start_i) begin
                    state_d = STOPPED;
                end
            end
            default: begin
                state_d = STOPPED;
            end
        endcase

        en_d   = (state_d != STOPPED);
        busy_d = (state_d == PENDING) || (state_d == STOPPING);
    end

    assign h_active_o = act[0];
    assign h_front_o  = act[1];
    assign h_sync_o   = act[2];
    assign h_total_o  = act[3];
    assign v_active_o = act[4];
    assign v_front_o  = act[5];
    assign v_sync_o   = act[6];
    assign v_total_o  = act[7];

endmodule

// File: tb/tb_video_mode_sequencer.sv
// Bench for video_mode_sequencer: directed vector table, then random traffic
// checked against a flag-level behavioural model of the sequencer.
module tb_video_mode_sequencer;

`ifdef VIDEO_SEQ_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, cfg_wr, commit, start, stop, fs;
    logic [2:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic        en, busy, done, err;
    logic [11:0] h_active, h_front, h_sync, h_total, v_active, v_front, v_sync, v_total;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    video_mode_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_wr_i     (cfg_wr),
        .cfg_addr_i   (cfg_addr),
        .cfg_data_i   (cfg_data),
        .commit_i     (commit),
        .start_i      (start),
        .stop_i       (stop),
        .frame_start_i(fs),
        .en_o         (en),
        .h_active_o   (h_active),
        .h_front_o    (h_front),
        .h_sync_o     (h_sync),
        .h_total_o    (h_total),
        .v_active_o   (v_active),
        .v_front_o    (v_front),
        .v_sync_o     (v_sync),
        .v_total_o    (v_total),
        .cfg_busy_o   (busy),
        .cfg_done_o   (done),
        .cfg_err_o    (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit rst, wr;
        int addr, data;
        bit commit, start, stop, fs;
        bit en, busy, done, err;
        int ha, ht, vt;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input bit r, w, input int a, d, input bit c, s, p, f,
                                input bit e, b, dn, er, input int ha, ht, vt);
        vec_t x;
        x.rst = r; x.wr = w; x.addr = a; x.data = d;
        x.commit = c; x.start = s; x.stop = p; x.fs = f;
        x.en = e; x.busy = b; x.done = dn; x.err = er;
        x.ha = ha; x.ht = ht; x.vt = vt;
        return x;
    endfunction

    task automatic drive(input bit r, w, input int a, d, input bit c, s, p, f);
        rst = r; cfg_wr = w; cfg_addr = 3'(a); cfg_data = 12'(d);
        commit = c; start = s; stop = p; fs = f;
    endtask

    // Behavioural model: enabled / commit-waiting / stop-requested flags
    int m_stg[8];
    int m_act[8];
    bit m_en, m_pend, m_stopreq, m_done, m_err;
    int def_set[8] = '{1920, 88, 44, 2200, 1080, 4, 5, 1125};
    int p720[8]    = '{1280, 110, 40, 1650, 720, 5, 5, 750};

    task automatic model_reset();
        m_stg = def_set; m_act = def_set;
        m_en = 0; m_pend = 0; m_stopreq = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model_step(input bit r, w, input int a, d, input bit c, s, p, f);
        bit b, ok, tr;
        if (r) begin
            model_reset();
            return;
        end
        b  = m_pend || m_stopreq;
        ok = !CHK || ((m_stg[0] + m_stg[1] + m_stg[2] < m_stg[3]) &&
                      (m_stg[4] + m_stg[5] + m_stg[6] < m_stg[7]));
        tr = c && !b;
        m_done = 0;
        if (tr && CHK) m_err = !ok;
        if (!m_en) begin
            if (tr && ok) begin m_act = m_stg; m_done = 1; end
            if (s && !p) m_en = 1;
        end else if (m_pend) begin
            if (p) m_stopreq = 1; else if (s) m_stopreq = 0;
            if (f) begin m_act = m_stg; m_done = 1; m_pend = 0; end
        end else if (m_stopreq) begin
            if (p) begin
                if (f) begin m_en = 0; m_stopreq = 0; end
            end else if (s) begin
                m_stopreq = 0;
            end else if (f) begin
                m_en = 0; m_stopreq = 0;
            end
        end else begin
            if (tr && ok) begin m_pend = 1; m_stopreq = p; end
            else if (p) m_stopreq = 1;
        end
        if (w && !b) m_stg[a] = d;
    endtask

    function automatic int pick_data(input int a);
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return $urandom_range(0, 4095);
        return (k < 5) ? def_set[a] : p720[a];
    endfunction

    initial begin
        int ht_bad;
        drive(1, 0, 0, 0, 0, 0, 0, 0);

        // reset defaults, start, stop at boundary
        vq.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,1,0,0, 1,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,1,0, 1,1,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,1,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1920,2200,1125));
        // commit while stopped
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(0,1,i,p720[i], 0,0,0,0, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 1,0,0,0, 0,0,1,0, 1280,1650,750));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 1280,1650,750));
        // commit while running, write during busy is dropped
        vq.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,1,0,0, 1,0,0,0, 1920,2200,1125));
        for (int i = 0; i < 8; i++)
            vq.push_back(mk(0,1,i,p720[i], 0,0,0,0, 1,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 1,0,0,0, 1,1,0,0, 1920,2200,1125));
        vq.push_back(mk(0,1,3,999, 0,0,0,0, 1,1,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,1,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,1, 1,0,1,0, 1280,1650,750));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,0,0,0, 1280,1650,750));
        vq.push_back(mk(0,0,0,0, 1,0,0,0, 1,1,0,0, 1280,1650,750));
        vq.push_back(mk(0,0,0,0, 0,0,0,1, 1,0,1,0, 1280,1650,750));
        // stop cancelled by start, then start+stop together
        vq.push_back(mk(0,0,0,0, 0,0,1,0, 1,1,0,0, 1280,1650,750));
        vq.push_back(mk(0,0,0,0, 0,1,0,0, 1,0,0,0, 1280,1650,750));
        vq.push_back(mk(0,0,0,0, 0,0,0,1, 1,0,0,0, 1280,1650,750));
        vq.push_back(mk(0,0,0,0, 0,1,1,0, 1,1,0,0, 1280,1650,750));
        vq.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 1280,1650,750));
        vq.push_back(mk(0,0,0,0, 0,1,1,0, 0,0,0,0, 1280,1650,750));
        // invalid commit at the exact boundary sum, stopped then running
        ht_bad = CHK ? 2200 : 2052;
        vq.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,1,3,2052, 0,0,0,0, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 1,0,0,0, 0,0,!CHK,CHK, 1920,ht_bad,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,CHK, 1920,ht_bad,1125));
        vq.push_back(mk(0,1,3,2053, 0,0,0,0, 0,0,0,CHK, 1920,ht_bad,1125));
        vq.push_back(mk(0,0,0,0, 1,0,0,0, 0,0,1,0, 1920,2053,1125));
        vq.push_back(mk(0,0,0,0, 0,1,0,0, 1,0,0,0, 1920,2053,1125));
        vq.push_back(mk(0,1,3,2052, 0,0,0,0, 1,0,0,0, 1920,2053,1125));
        vq.push_back(mk(0,0,0,0, 1,0,0,0, 1,!CHK,0,CHK, 1920,2053,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,1, 1,0,!CHK,CHK, 1920,CHK ? 2053 : 2052,1125));
        // commit and stop together: apply at first boundary, stop at second
        vq.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,1,0,0, 1,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,1,3,2100, 0,0,0,0, 1,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 1,0,1,0, 1,1,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,1,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,1, 1,1,1,0, 1920,2100,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,1,0,0, 1920,2100,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 1920,2100,1125));
        // reset while pending discards commit and restores staging
        vq.push_back(mk(0,0,0,0, 0,1,0,0, 1,0,0,0, 1920,2100,1125));
        vq.push_back(mk(0,1,3,2300, 0,0,0,0, 1,0,0,0, 1920,2100,1125));
        vq.push_back(mk(0,0,0,0, 1,0,0,0, 1,1,0,0, 1920,2100,1125));
        vq.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 1920,2200,1125));
        vq.push_back(mk(0,0,0,0, 1,0,0,0, 0,0,1,0, 1920,2200,1125));

        foreach (vq[n]) begin
            drive(vq[n].rst, vq[n].wr, vq[n].addr, vq[n].data,
                  vq[n].commit, vq[n].start, vq[n].stop, vq[n].fs);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d en", n),       32'(en),       32'(vq[n].en));
            check($sformatf("vec%0d busy", n),     32'(busy),     32'(vq[n].busy));
            check($sformatf("vec%0d done", n),     32'(done),     32'(vq[n].done));
            check($sformatf("vec%0d err", n),      32'(err),      32'(vq[n].err));
            check($sformatf("vec%0d h_active", n), 32'(h_active), vq[n].ha);
            check($sformatf("vec%0d h_total", n),  32'(h_total),  vq[n].ht);
            check($sformatf("vec%0d v_total", n),  32'(v_total),  vq[n].vt);
        end

        // random traffic against the model
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            bit r, w, c, s, p, f;
            int a, d;
            r = (n == 0) || ($urandom_range(0, 199) == 0);
            w = ($urandom_range(0, 9) < 3);
            a = $urandom_range(0, 7);
            d = pick_data(a);
            c = ($urandom_range(0, 9) == 0);
            s = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 19) == 0);
            f = ($urandom_range(0, 19) == 0);
            drive(r, w, a, d, c, s, p, f);
            @(posedge clk);
            model_step(r, w, a, d, c, s, p, f);
            #1;
            check($sformatf("rnd%0d en", n),       32'(en),       32'(m_en));
            check($sformatf("rnd%0d busy", n),     32'(busy),     32'(m_pend || m_stopreq));
            check($sformatf("rnd%0d done", n),     32'(done),     32'(m_done));
            check($sformatf("rnd%0d err", n),      32'(err),      32'(m_err));
            check($sformatf("rnd%0d h_active", n), 32'(h_active), m_act[0]);
            check($sformatf("rnd%0d h_front", n),  32'(h_front),  m_act[1]);
            check($sformatf("rnd%0d h_sync", n),   32'(h_sync),   m_act[2]);
            check($sformatf("rnd%0d h_total", n),  32'(h_total),  m_act[3]);
            check($sformatf("rnd%0d v_active", n), 32'(v_active), m_act[4]);
            check($sformatf("rnd%0d v_front", n),  32'(v_front),  m_act[5]);
            check($sformatf("rnd%0d v_sync", n),   32'(v_sync),   m_act[6]);
            check($sformatf("rnd%0d v_total", n),  32'(v_total),  m_act[7]);
        end

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_mode_sequencer.md
# video_mode_sequencer

Control-plane block that sequences and configures the HDMI timing core (`hdmi_controller`). It does three things: gates the core's `en_i`, holds the eight video timing values the core consumes, and accepts new timing values through a small write port. New values take effect only at a frame boundary, so a running output never sees a torn frame. It sits between the system configuration master and the HDMI timing core.

## Interface
- `TW`, 12: width of every timing value.
- `H_ACTIVE_DEF`, `H_FRONT_DEF`, `H_SYNC_DEF`, `H_TOTAL_DEF`, defaults 1920, 88, 44, 2200: reset horizontal timing.
- `V_ACTIVE_DEF`, `V_FRONT_DEF`, `V_SYNC_DEF`, `V_TOTAL_DEF`, defaults 1080, 4, 5, 1125: reset vertical timing.

Ports (name, direction, width, meaning):
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `cfg_wr_i` in 1: write strobe into the staging registers.
- `cfg_addr_i` in 3: register select. 0 H_ACTIVE, 1 H_FRONT, 2 H_SYNC, 3 H_TOTAL, 4 V_ACTIVE, 5 V_FRONT, 6 V_SYNC, 7 V_TOTAL.
- `cfg_data_i` in TW: write data.
- `commit_i` in 1: pulse; request that the staged set becomes the active set.
- `start_i` in 1: pulse; enable video output.
- `stop_i` in 1: pulse; disable video output at the next frame boundary.
- `frame_start_i` in 1: pulse from the timing core on the first cycle of each frame.
- `en_o` out 1: drives the timing core's `en_i`.
- `h_active_o`, `h_front_o`, `h_sync_o`, `h_total_o`, `v_active_o`, `v_front_o`, `v_sync_o`, `v_total_o` out TW each: active timing set.
- `cfg_busy_o` out 1: a commit is pending; writes and commits are ignored while high.
- `cfg_done_o` out 1: one-cycle pulse on the cycle the active set updates.
- `cfg_err_o` out 1: sticky; the last commit was rejected. Cleared by the next accepted commit.

## Operation
- **FSM states:** STOPPED, RUN, PENDING, STOPPING.
- **Reset:** state STOPPED.
  - `en_o`=0, `cfg_busy_o`=0, `cfg_done_o`=0, `cfg_err_o`=0.
  - Staging and active registers both load the `*_DEF` parameters.
- **Staging writes:** `cfg_wr_i` writes `cfg_data_i` into `staging[cfg_addr_i]` unless `cfg_busy_o`=1. Writes never alter the active outputs.
- **Validity check** (see Configuration). A staged set is valid iff both hold:
  - `h_active + h_front + h_sync < h_total`
  - `v_active + v_front + v_sync < v_total`
  - Sums are computed at TW+2 bits, so no wrap.
  - An invalid commit is dropped, `cfg_err_o` goes to 1, and the state is unchanged.
- **STOPPED:**
  - valid `commit_i`: copy staging to active, pulse `cfg_done_o`.
  - `start_i`: go to RUN.
- **RUN:**
  - valid `commit_i`: go to PENDING.
  - `stop_i`: go to STOPPING.
  - `start_i`: ignored.
- **PENDING:** on `frame_start_i`, copy staging to active, pulse `cfg_done_o`, then:
  - go to STOPPING if a stop was latched while PENDING;
  - otherwise go to RUN.
- **STOPPING:**
  - `frame_start_i`: go to STOPPED.
  - `commit_i`: ignored; `cfg_busy_o`=1 in this state.
  - `start_i`: cancels the stop; return to RUN.
- **Simultaneous events:**
  - `commit_i` and `stop_i` in the same RUN cycle: go to PENDING with the stop latched. The config applies at the boundary, then the block stops at the following boundary.
  - `start_i` and `stop_i` together: `stop_i` wins.

## Timing
- Registered outputs only.
- `start_i` in STOPPED at cycle N gives `en_o`=1 at N+1.
- Commit in STOPPED at cycle N:
  - active outputs are new at N+1;
  - `cfg_done_o`=1 during N+1 only.
- Commit in RUN at N: `cfg_busy_o`=1 from N+1.
- `frame_start_i` in PENDING at cycle F:
  - active outputs are new at F+1;
  - `cfg_done_o`=1 during F+1;
  - `cfg_busy_o`=0 at F+1.
- `frame_start_i` in STOPPING at F: `en_o`=0 at F+1.
- Staging write at N: visible to the validity check at N+1. A commit in the same cycle as a write uses the pre-write staging.
- `rst_i` mid-operation: next-cycle values equal the reset values, including restoring the active set to the defaults. Any pending commit or stop is discarded.

## Configuration
- **`VIDEO_SEQ_CHECK_EN` defined:** validity check present, `cfg_err_o` functional.
- **Not defined:** every commit is accepted, `cfg_err_o` is tied to 0, and the adder logic is absent.

## Test plan
- **Reset defaults:** reset, then `start_i`. Expect `en_o`=1 one cycle later, and `h_total_o`=2200 and `v_total_o`=1125 throughout.
- **Commit while stopped:** write H_ACTIVE=1280, H_FRONT=110, H_SYNC=40, H_TOTAL=1650, V_ACTIVE=720, V_FRONT=5, V_SYNC=5, V_TOTAL=750, then `commit_i`. Expect all outputs updated next cycle, one `cfg_done_o` pulse, `cfg_err_o`=0.
- **Commit while running:** in RUN, commit the 720p set. Expect:
  - outputs unchanged and `cfg_busy_o`=1 until `frame_start_i`;
  - outputs switch the cycle after `frame_start_i`;
  - a write during busy does not alter staging.
- **Invalid commit** (`VIDEO_SEQ_CHECK_EN` defined): H_TOTAL=2052 with defaults (1920+88+44=2052). Expect commit rejected, `cfg_err_o`=1, outputs unchanged. Without the macro, expect h_total_o=2052 and `cfg_err_o`=0.
- **Stop at boundary:** in RUN, `stop_i`. Expect `en_o` held at 1 until `frame_start_i`, then 0 next cycle. Repeat with `start_i` before the boundary: expect `en_o` to stay 1.
- **Simultaneous commit and stop:** `commit_i` and `stop_i` together in RUN. Expect the new config at the first `frame_start_i`, then `en_o`=0 after the second. Assert `rst_i` mid-PENDING in a separate run: expect defaults and STOPPED next cycle.
